// File: rtl/raster_timing_if.sv
// raster_timing_if: renderer and HDMI pin bundle around the raster timing generator.
//   x, y        : current pixel position presented to the renderer
//   r, g, b     : renderer colour returned for an earlier position
//   hdmi_*      : registered transmitter pins (clock, data, DE, HSYNC, VSYNC)
//   frame_start : one-cycle pulse on the tick at position (0,0)
//   line_start  : one-cycle pulse on every tick at x == 0
// master = timing generator side, slave = renderer / transmitter side.
interface raster_timing_if;
  logic [11:0] x;
  logic [11:0] y;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        hdmi_clk;
  logic [23:0] hdmi_d;
  logic        hdmi_de;
  logic        hdmi_hs;
  logic        hdmi_vs;
  logic        frame_start;
  logic        line_start;

  modport master (
    output x, y, hdmi_clk, hdmi_d, hdmi_de, hdmi_hs, hdmi_vs, frame_start, line_start,
    input  r, g, b
  );

  modport slave (
    input  x, y, hdmi_clk, hdmi_d, hdmi_de, hdmi_hs, hdmi_vs, frame_start, line_start,
    output r, g, b
  );
endinterface

// File: rtl/raster_timing.sv
// raster_timing: display timing generator and HDMI output register stage.
// Runs on the system clock; all timing advances only on the pixel tick pix_ce.
// Ports:
//   clk     : system clock
//   resetn  : synchronous active-low reset
//   pix_ce  : pixel tick, one clk wide
//   bus     : raster_timing_if.master (x/y out, r/g/b in, hdmi_* pins, start pulses)
// Sync/DE are delayed PIX_LAT ticks so they line up with the renderer's colour.
module raster_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PIX_LAT  = 1
) (
  input logic             clk,
  input logic             resetn,
  input logic             pix_ce,
  raster_timing_if.master bus
);

  localparam int unsigned CW       = 12;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned SRW      = (PIX_LAT == 0) ? 3 : 3 * PIX_LAT;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic [2:0]    raw;      // {de, hs, vs}, active-high
  logic [2:0]    dly;      // raw delayed PIX_LAT ticks
  logic          ce_d;
  logic          hdmi_clk_q;
  logic [23:0]   hdmi_d_q;
  logic          hdmi_de_q;
  logic          hdmi_hs_q;
  logic          hdmi_vs_q;

  // Pixel/line counters; vcnt steps on the hcnt wrap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_ce) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
      end else begin
        hcnt <= hcnt + CW'(1);
      end
    end
  end

  // Raw timing decode from the current position.
  always_comb begin
    raw    = 3'b000;
    raw[2] = (hcnt < H_ACT) && (vcnt < V_ACT);
    raw[1] = (hcnt >= HS_START) && (hcnt < HS_END);
    raw[0] = (vcnt >= VS_START) && (vcnt < VS_END);
  end

  // Latency-matching shift register; PIX_LAT == 0 bypasses it.
  generate
    if (PIX_LAT == 0) begin : g_nodly
      assign dly = raw;
    end else begin : g_dly
      logic [SRW-1:0] sr;
      always_ff @(posedge clk) begin
        if (!resetn) begin
          sr <= '0;
        end else if (pix_ce) begin
          sr <= SRW'({sr, raw});
        end
      end
      assign dly = sr[SRW-1 -: 3];
    end
  endgenerate

  // Output registers. hdmi_clk falls on a tick and rises on the next edge,
  // so only a tick followed by an idle cycle produces a rising edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ce_d       <= 1'b0;
      hdmi_clk_q <= 1'b0;
      hdmi_d_q   <= '0;
      hdmi_de_q  <= 1'b0;
      hdmi_hs_q  <= ~HS_POL;
      hdmi_vs_q  <= ~VS_POL;
    end else begin
      ce_d <= pix_ce;
      if (pix_ce) begin
        hdmi_clk_q <= 1'b0;
        hdmi_de_q  <= dly[2];
        hdmi_hs_q  <= dly[1] ? HS_POL : ~HS_POL;
        hdmi_vs_q  <= dly[0] ? VS_POL : ~VS_POL;
        hdmi_d_q   <= dly[2] ? {bus.r, bus.g, bus.b} : 24'h000000;
      end else if (ce_d) begin
        hdmi_clk_q <= 1'b1;
      end
    end
  end

  assign bus.x           = hcnt;
  assign bus.y           = vcnt;
  assign bus.hdmi_clk    = hdmi_clk_q;
  assign bus.hdmi_d      = hdmi_d_q;
  assign bus.hdmi_de     = hdmi_de_q;
  assign bus.hdmi_hs     = hdmi_hs_q;
  assign bus.hdmi_vs     = hdmi_vs_q;
  assign bus.line_start  = pix_ce && (hcnt == '0);
  assign bus.frame_start = pix_ce && (hcnt == '0) && (vcnt == '0);

endmodule

// File: tb/tb_raster_timing.sv
// tb_raster_timing: scoreboard bench for raster_timing with default horizontal
// timing and an 8-line frame (4 active, 1 FP, 2 sync, 1 BP).
module tb_raster_timing;
  localparam int unsigned VA    = 4;
  localparam int unsigned VF    = 1;
  localparam int unsigned VS    = 2;
  localparam int unsigned VB    = 1;
  localparam int unsigned LAT   = 1;
  localparam int unsigned HT    = 800;
  localparam int unsigned VT    = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] d;
    logic [11:0] px;
    logic [11:0] py;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic pix_ce = 1'b0;

  raster_timing_if rif ();

  raster_timing #(
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .PIX_LAT  (LAT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .pix_ce (pix_ce),
    .bus    (rif)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  exp_t        q[$];
  exp_t        last;
  int unsigned mh, mv;
  logic        got_fs;
  int          rise_cnt;

  // Model position (mh,mv) is the one the DUT should be presenting.
  task automatic tick(input int gap);
    exp_t e;
    logic [11:0] cx, cy;
    pix_ce = 1'b1;
    #1;
    checks++;
    if (rif.x !== 12'(mh) || rif.y !== 12'(mv))
      $display("FAIL pos: x=%0d y=%0d required %0d,%0d", rif.x, rif.y, mh, mv);
    else passes++;
    checks++;
    if (rif.line_start !== (mh == 0) || rif.frame_start !== (mh == 0 && mv == 0))
      $display("FAIL start: ls=%b fs=%b at %0d,%0d", rif.line_start, rif.frame_start, mh, mv);
    else passes++;
    got_fs = rif.frame_start;
    e.de = (mh < 640) && (mv < VA);
    e.hs = !((mh >= 656) && (mh < 752));
    e.vs = !((mv >= VA + VF) && (mv < VA + VF + VS));
    e.d  = e.de ? {8'(mh), 8'(mv), 8'hA5} : 24'h000000;
    e.px = 12'(mh);
    e.py = 12'(mv);
    q.push_back(e);
    cx = rif.x;
    cy = rif.y;
    @(posedge clk);
    #1;
    pix_ce = 1'b0;
    {rif.r, rif.g, rif.b} = {cx[7:0], cy[7:0], 8'hA5};
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    checks++;
    if (q.size() == 0) begin
      $display("FAIL sb_empty: queue size 0 required >0");
    end else begin
      last = q.pop_front();
      if ({rif.hdmi_de, rif.hdmi_hs, rif.hdmi_vs, rif.hdmi_d} !== {last.de, last.hs, last.vs, last.d})
        $display("FAIL out(%0d,%0d): de/hs/vs/d=%b%b%b %h required %b%b%b %h", last.px, last.py,
                 rif.hdmi_de, rif.hdmi_hs, rif.hdmi_vs, rif.hdmi_d, last.de, last.hs, last.vs, last.d);
      else passes++;
    end
    checks++;
    if (rif.hdmi_clk !== 1'b0) $display("FAIL clk_low: hdmi_clk=%b required 0", rif.hdmi_clk);
    else passes++;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        checks++;
        if (rif.hdmi_clk !== 1'b1) $display("FAIL clk_high: hdmi_clk=%b required 1", rif.hdmi_clk);
        else begin passes++; rise_cnt++; end
      end
    end
    if (gap > 0) begin
      checks++;
      if (rif.hdmi_de !== last.de || rif.hdmi_d !== last.d || rif.x !== 12'(mh) || rif.frame_start !== 1'b0)
        $display("FAIL hold: de=%b d=%h x=%0d fs=%b required %b %h %0d 0",
                 rif.hdmi_de, rif.hdmi_d, rif.x, rif.frame_start, last.de, last.d, mh);
      else passes++;
    end
  endtask

  task automatic do_reset();
    exp_t e;
    pix_ce = 1'b0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rif.x !== 12'd0 || rif.y !== 12'd0)
      $display("FAIL rst_xy: x=%0d y=%0d required 0,0", rif.x, rif.y);
    else passes++;
    checks++;
    if (rif.hdmi_de !== 1'b0 || rif.hdmi_d !== 24'h000000)
      $display("FAIL rst_de_d: de=%b d=%h required 0 000000", rif.hdmi_de, rif.hdmi_d);
    else passes++;
    checks++;
    if (rif.hdmi_hs !== 1'b1 || rif.hdmi_vs !== 1'b1)
      $display("FAIL rst_sync: hs=%b vs=%b required 1 1", rif.hdmi_hs, rif.hdmi_vs);
    else passes++;
    checks++;
    if (rif.hdmi_clk !== 1'b0) $display("FAIL rst_clk: hdmi_clk=%b required 0", rif.hdmi_clk);
    else passes++;
    resetn = 1'b1;
    q.delete();
    e = '{de: 1'b0, hs: 1'b1, vs: 1'b1, d: 24'h0, px: 12'hFFF, py: 12'hFFF};
    for (int i = 0; i < int'(LAT); i++) q.push_back(e);
    mh = 0;
    mv = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rif.frame_start !== 1'b0 || rif.line_start !== 1'b0)
      $display("FAIL rst_pulses: fs=%b ls=%b required 0 0", rif.frame_start, rif.line_start);
    else passes++;
  endtask

  task automatic test_frames();
    int   fs_t[$];
    int   de_n = 0, vs_n = 0, hs_n = 0, ovl = 0, dz = 0, vs_bad = 0;
    int   hs_first = -1, hs_last = -1;
    logic have_first = 1'b0, have_corner = 1'b0;
    logic [23:0] first_d = 24'h0, corner = 24'h0;
    logic prev_vs = 1'b1;
    do_reset();
    for (int t = 0; t <= int'(2 * FRAME); t++) begin
      tick(1);
      if (got_fs) fs_t.push_back(t);
      if (rif.hdmi_de) de_n++;
      if (!rif.hdmi_vs) vs_n++;
      if (!rif.hdmi_hs) hs_n++;
      if (rif.hdmi_de && !rif.hdmi_hs) ovl++;
      if (!rif.hdmi_de && rif.hdmi_d !== 24'h0) dz++;
      if (rif.hdmi_vs !== prev_vs && last.px != 12'd0) vs_bad++;
      prev_vs = rif.hdmi_vs;
      if (!rif.hdmi_hs && last.py == 12'd0) begin
        if (hs_first < 0) hs_first = int'(last.px);
        hs_last = int'(last.px);
      end
      if (rif.hdmi_de && !have_first) begin first_d = rif.hdmi_d; have_first = 1'b1; end
      if (last.px == 12'd639 && last.py == 12'(VA - 1) && !have_corner) begin
        corner = rif.hdmi_d; have_corner = 1'b1;
      end
    end
    checks++;
    if (fs_t.size() != 3) $display("FAIL fs_count: %0d required 3", fs_t.size());
    else passes++;
    if (fs_t.size() == 3) begin
      checks++;
      if (fs_t[1] - fs_t[0] != int'(FRAME) || fs_t[2] - fs_t[1] != int'(FRAME))
        $display("FAIL fs_interval: %0d %0d required %0d", fs_t[1] - fs_t[0], fs_t[2] - fs_t[1], FRAME);
      else passes++;
    end
    checks++;
    if (de_n != 2 * 640 * int'(VA)) $display("FAIL de_ticks: %0d required %0d", de_n, 2 * 640 * VA);
    else passes++;
    checks++;
    if (vs_n != 2 * 1600) $display("FAIL vs_ticks: %0d required 3200", vs_n);
    else passes++;
    checks++;
    if (hs_n != 2 * 96 * int'(VT)) $display("FAIL hs_ticks: %0d required %0d", hs_n, 2 * 96 * VT);
    else passes++;
    checks++;
    if (ovl != 0 || dz != 0) $display("FAIL de_overlap: ovl=%0d dnz=%0d required 0 0", ovl, dz);
    else passes++;
    checks++;
    if (vs_bad != 0) $display("FAIL vs_align: %0d off-line-start edges required 0", vs_bad);
    else passes++;
    checks++;
    if (hs_first != 656 || hs_last != 751)
      $display("FAIL hs_window: %0d..%0d required 656..751", hs_first, hs_last);
    else passes++;
    checks++;
    if (first_d !== 24'h0000A5) $display("FAIL first_pixel: %h required 0000a5", first_d);
    else passes++;
    checks++;
    if (corner !== 24'h7F03A5) $display("FAIL corner_pixel: %h required 7f03a5", corner);
    else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int t = 0; t < 5 * int'(HT) + 300; t++) tick(1);
    checks++;
    if (rif.hdmi_vs !== 1'b0 || mh != 300) $display("FAIL mid_vs: vs=%b x=%0d required 0 300", rif.hdmi_vs, mh);
    else passes++;
    do_reset();
    tick(1);
    checks++;
    if (got_fs !== 1'b1) $display("FAIL mid_fs: frame_start=%b required 1", got_fs);
    else passes++;
    for (int t = 0; t < 20; t++) tick(1);
  endtask

  task automatic test_irregular();
    int fs_t[$];
    int de_n = 0, vs_n = 0;
    do_reset();
    rise_cnt = 0;
    for (int t = 0; t <= int'(FRAME); t++) begin
      tick(int'($urandom_range(5, 1)));
      if (got_fs) fs_t.push_back(t);
      if (rif.hdmi_de) de_n++;
      if (!rif.hdmi_vs) vs_n++;
    end
    checks++;
    if (fs_t.size() != 2 || fs_t[1] - fs_t[0] != int'(FRAME))
      $display("FAIL irr_frame: %0d pulses required 2 spaced %0d", fs_t.size(), FRAME);
    else passes++;
    checks++;
    if (de_n != 640 * int'(VA) || vs_n != 1600)
      $display("FAIL irr_de_vs: de=%0d vs=%0d required %0d 1600", de_n, vs_n, 640 * VA);
    else passes++;
    checks++;
    if (rise_cnt != int'(FRAME) + 1) $display("FAIL irr_rises: %0d required %0d", rise_cnt, FRAME + 1);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] x0;
    x0 = rif.x;
    for (int i = 0; i < 5; i++) tick(0);
    checks++;
    if (rif.x !== x0 + 12'd5 || rif.hdmi_clk !== 1'b0)
      $display("FAIL b2b: x=%0d clk=%b required %0d 0", rif.x, rif.hdmi_clk, x0 + 12'd5);
    else passes++;
    for (int i = 0; i < 4; i++) tick(1);
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL timeout: run exceeded 150000 cycles");
    $fatal(1);
  end

  initial begin
    rif.r = 8'h00;
    rif.g = 8'h00;
    rif.b = 8'h00;
    rise_cnt = 0;
    got_fs = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_frames();
    test_reset_mid();
    test_irregular();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
